// File: rtl/wallace_mac_sequencer.sv
// Streaming multiply-accumulate sequencer around an external 8x8 Wallace tree.
// Define WALLACE_MAC_SATURATE_EN to clamp the accumulator instead of wrapping.
module wallace_mac_sequencer #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count;
  logic             pv;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   sum;
  logic             fire;

  assign in_ready  = (state == RUN) && (count < len);
  assign fire      = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_acc   = acc;

  // Extra bit captures the carry-out of the accumulate.
  assign sum = {1'b0, acc} + (ACC_W+1)'(mul_p);

`ifdef WALLACE_MAC_SATURATE_EN
  assign acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      count    <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      pv       <= 1'b0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (pv) begin
        acc      <= acc_next;
        overflow <= overflow | sum[ACC_W];
      end
      pv <= fire;
      if (fire) begin
        mul_a <= in_a;
        mul_b <= in_b;
        count <= count + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            pv       <= 1'b0;
            len      <= vec_len;
            state    <= (vec_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fire && (count + 1'b1 == len))
            state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// Randomized scoreboard bench for wallace_mac_sequencer.
// Expected results come from an arithmetic dot-product model.
module tb_wallace_mac_sequencer;

  localparam int ACC_W = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] vec_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_p;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_acc;
  logic             overflow;
  logic             busy;

  wallace_mac_sequencer #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .overflow(overflow), .busy(busy)
  );

  // Stand-in for the Wallace tree.
  assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] va[$];
  logic [7:0] vb[$];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int len);
    exp_t        e;
    longint      s;
    longint      lim;
    bit          ovf;
    s   = 0;
    ovf = 0;
    lim = longint'(1) << ACC_W;
    for (int i = 0; i < len; i++) begin
      s = s + longint'(va[i]) * longint'(vb[i]);
      if (s >= lim) begin
        ovf = 1;
`ifdef WALLACE_MAC_SATURATE_EN
        s = lim - 1;
`else
        s = s - lim;
`endif
      end
    end
    e.acc = s[ACC_W-1:0];
    e.ovf = ovf;
    return e;
  endfunction

  // Monitor: compare each completed result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out_acc", out_acc, e.acc);
        check("overflow", overflow, e.ovf);
      end
    end
  end

  task automatic run_vector(input int len, input int gap, input int hold);
    exp_t       e;
    int         i;
    int         k;
    int         idle;
    bit         fire;
    logic [7:0] la;
    logic [7:0] lb;
    la = '0;
    lb = '0;
    e = model(len);
    @(posedge clk); #1;
    start   = 1'b1;
    vec_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    k = 0;
    idle = gap;
    while (i < len && k < 200) begin
      in_valid = (idle >= gap);
      in_a = va[i];
      in_b = vb[i];
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) begin
        la = va[i];
        lb = vb[i];
        i++;
        idle = 0;
      end else begin
        idle++;
        if (i > 0) begin
          check("mul_a_hold", mul_a, la);
          check("mul_b_hold", mul_b, lb);
        end
      end
      k++;
    end
    in_valid = 1'b0;
    if (i < len) check("accept_timeout", i, len);
    sbq.push_back(e);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_latency", k, (len == 0) ? 0 : 1);
    check("in_ready_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      start   = 1'b1;
      vec_len = 8'd3;
      check("acc_hold", out_acc, e.acc);
      check("valid_hold", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_ack", busy, 0);
    check("valid_drop", out_valid, 0);
  endtask

  task automatic load(input logic [7:0] a[$], input logic [7:0] b[$]);
    va = a;
    vb = b;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    check("rst_mul_a", mul_a, 0);
    check("rst_acc", out_acc, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic dot product: 6 + 20 + 65025.
    load('{8'd2, 8'd4, 8'd255}, '{8'd3, 8'd5, 8'd255});
    check("model_basic", model(3).acc, 65051);
    run_vector(3, 0, 0);

    // Throttled input with 3 idle cycles between beats.
    load('{8'd10, 8'd1}, '{8'd10, 8'd1});
    run_vector(2, 3, 0);

    // Zero length.
    run_vector(0, 0, 2);

    // Wrap/saturate with backpressure and ignored start.
    load('{8'd255, 8'd255}, '{8'd255, 8'd255});
`ifdef WALLACE_MAC_SATURATE_EN
    check("model_sat", model(2).acc, 16'hFFFF);
`else
    check("model_wrap", model(2).acc, 16'hFC02);
`endif
    run_vector(2, 0, 5);

    // Reset mid-vector after two of five beats.
    load('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5});
    @(posedge clk); #1;
    start   = 1'b1;
    vec_len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_mul_a", mul_a, 0);
    check("arst_mul_b", mul_b, 0);
    check("arst_acc", out_acc, 0);
    check("arst_ovf", overflow, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load('{8'd7}, '{8'd9});
    run_vector(1, 0, 0);

    // Randomized vectors.
    for (int t = 0; t < 12; t++) begin
      va.delete();
      vb.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        va.push_back(8'($urandom));
        vb.push_back(8'($urandom));
      end
      run_vector(n, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
